// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: game FSM, balls-remaining counter and 2-digit BCD score.
// Optional bonus-ball logic is built only when PONG_BONUS_BALL_EN is defined.
module pong_game_ctrl #(
  parameter int BALLS      = 3,
  parameter int BONUS_HITS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  input  logic       timer_up,
  output logic       timer_start,
  output logic       gra_still,
  output logic [1:0] text_state,
  output logic [1:0] ball_cnt,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic       bonus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] BALLS_L = 2'(BALLS);

  state_t     state, state_n;
  logic [1:0] ball_n;
  logic [3:0] dig0_n, dig1_n;
  logic       press;
  logic       bonus_hit;

  assign press = |btn;

`ifdef PONG_BONUS_BALL_EN
  logic [7:0] hit_cnt;
  logic       accept_hit;
  logic       clear_hits;

  assign accept_hit = (state == PLAY) && hit && !miss;
  assign clear_hits = (state == NEWGAME) && press;
  assign bonus_hit  = accept_hit && (hit_cnt == 8'(BONUS_HITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt <= '0;
      bonus   <= 1'b0;
    end else begin
      bonus <= bonus_hit;
      if (clear_hits)
        hit_cnt <= '0;
      else if (accept_hit)
        hit_cnt <= bonus_hit ? '0 : hit_cnt + 8'd1;
    end
  end
`else
  assign bonus_hit = 1'b0;
  assign bonus     = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    ball_n      = ball_cnt;
    dig0_n      = dig0;
    dig1_n      = dig1;
    timer_start = 1'b0;
    case (state)
      NEWGAME: begin
        ball_n = BALLS_L;
        if (press) begin
          state_n = PLAY;
          dig0_n  = '0;
          dig1_n  = '0;
          ball_n  = BALLS_L - 2'd1;
        end
      end
      PLAY: begin
        if (miss) begin
          timer_start = 1'b1;
          if (ball_cnt == 2'd0) begin
            state_n = OVER;
          end else begin
            ball_n  = ball_cnt - 2'd1;
            state_n = NEWBALL;
          end
        end else if (hit) begin
          if (dig0 == 4'd9) begin
            dig0_n = '0;
            dig1_n = (dig1 == 4'd9) ? 4'd0 : dig1 + 4'd1;
          end else begin
            dig0_n = dig0 + 4'd1;
          end
          if (bonus_hit && (ball_cnt < BALLS_L))
            ball_n = ball_cnt + 2'd1;
        end
      end
      NEWBALL: begin
        if (timer_up && press)
          state_n = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_n = NEWGAME;
          ball_n  = BALLS_L;
        end
      end
      default: state_n = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NEWGAME;
      ball_cnt <= BALLS_L;
      dig0     <= '0;
      dig1     <= '0;
    end else begin
      state    <= state_n;
      ball_cnt <= ball_n;
      dig0     <= dig0_n;
      dig1     <= dig1_n;
    end
  end

  assign text_state = state;
  assign gra_still  = (state != PLAY);

endmodule
